fetch_unit: RTL

- Parametrised instruction-fetch front end that replaces the fixed "PC + 1 every cycle" sequencing of the single-cycle core.
- Generates word addresses and issues them to a program memory with a valid/ready request channel and an in-order response channel of arbitrary latency (≥1).
- Buffers fetched instructions with their PCs in a queue feeding decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of queued and in-flight fetches.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch front end.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF      = 12;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned QUEUE_DEPTH_DEF = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

  typedef logic [$clog2(QUEUE_DEPTH_DEF+1)-1:0] fetch_cnt_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and async active-low reset.
module sync_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign do_push  = push && (count_q != DEPTH_C);
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into an instruction queue, and redirect with stale-response discard.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEF,
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter int unsigned       QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned CNT_W = cnt_width(QUEUE_DEPTH);
  localparam logic [CNT_W:0] DEPTH_C = QUEUE_DEPTH[CNT_W:0];

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d, stale_q, stale_d, occupancy;
  logic              credit, req_fire, push, pop, fifo_empty;
  entry_t            push_entry, head;

  // Queue slots are reserved at request time, so the queue can never overflow.
  assign credit         = ({1'b0, occupancy} + {1'b0, outstanding_q}) < DEPTH_C;
  assign imem_req_valid = reset && credit && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push       = imem_rsp_valid && (stale_q == '0) && !redirect_valid;
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
  assign pop        = !fifo_empty && out_ready;

  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    stale_d       = stale_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      // Everything still in flight after this cycle belongs to the old path.
      stale_d    = outstanding_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      if (push)     rsp_pc_d   = rsp_pc_q + ADDR_W'(1);
      if (imem_rsp_valid && (stale_q != '0)) stale_d = stale_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  sync_fifo #(
    .T     (entry_t),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

endmodule
